// File: rtl/binbcd_pkg.sv
// rtl/binbcd_pkg.sv - shared constants and FSM encoding for the ASCII/BCD/binary number paths
package binbcd_pkg;

    localparam logic [7:0] ASCII_CERO  = 8'h30;
    localparam logic [7:0] ASCII_NUEVE = 8'h39;
    localparam logic [7:0] TERM_DEF    = 8'h23;
    localparam int         MAX_VAL_DEF = 8191;
    localparam int         BCD_DIGITOS = 4;

    typedef enum logic [1:0] {
        CAPTURA   = 2'd0,
        CONVIERTE = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    function automatic logic es_digito(input logic [7:0] c);
        return (c >= ASCII_CERO) && (c <= ASCII_NUEVE);
    endfunction

endpackage

// File: rtl/ajuste_bcd_inv.sv
// rtl/ajuste_bcd_inv.sv - one inverse double-dabble step on a {bcd[31:16], bin[15:0]} register
module ajuste_bcd_inv
    import binbcd_pkg::*;
(
    input  logic [31:0] dato_i,
    output logic [31:0] dato_o
);

    // After the right shift a BCD nibble >= 8 carries a borrowed 10 that must become 5.
    always_comb begin
        dato_o = {1'b0, dato_i[31:1]};
        for (int i = 0; i < BCD_DIGITOS; i++) begin
            if (dato_o[16 + 4*i +: 4] >= 4'd8) begin
                dato_o[16 + 4*i +: 4] = dato_o[16 + 4*i +: 4] - 4'd3;
            end
        end
    end

endmodule

// File: rtl/ascii_a_bin.sv
// rtl/ascii_a_bin.sv - collects ASCII decimal digits up to a terminator and converts them to binary
module ascii_a_bin
    import binbcd_pkg::*;
#(
    parameter logic [7:0] TERM    = TERM_DEF,
    parameter int         MAX_DIG = 4,
    parameter int         MAX_VAL = MAX_VAL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        ready,
    output logic [12:0] numero,
    output logic        numero_valid,
    output logic        error
);

    localparam int             CW      = $clog2(MAX_DIG + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_DIG);
    localparam logic [CW-1:0]  CNT_UNO = CW'(1);
    localparam logic [15:0]    LIMITE  = 16'(MAX_VAL);

    estado_t        estado_q, estado_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           poison_q, poison_d;
    logic           rechazo_q, rechazo_d;
    logic [31:0]    shreg_q, shreg_d;
    logic [3:0]     iter_q, iter_d;
    logic [12:0]    numero_q, numero_d;
    logic           nvalid_q, nvalid_d;
    logic           error_q, error_d;
    logic [31:0]    ajustado;

    ajuste_bcd_inv u_ajuste (
        .dato_i (shreg_q),
        .dato_o (ajustado)
    );

    always_comb begin
        estado_d  = estado_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        poison_d  = poison_q;
        rechazo_d = rechazo_q;
        shreg_d   = shreg_q;
        iter_d    = iter_q;
        numero_d  = numero_q;
        nvalid_d  = 1'b0;
        error_d   = 1'b0;

        case (estado_q)
            CAPTURA: begin
                if (char_valid) begin
                    if (char_in == TERM) begin
                        if (poison_q || (cnt_q == '0)) begin
                            rechazo_d = 1'b1;
                            estado_d  = RESULTADO;
                        end else begin
                            rechazo_d = 1'b0;
                            shreg_d   = {bcd_q, 16'h0000};
                            iter_d    = 4'd0;
                            estado_d  = CONVIERTE;
                        end
                    end else if (es_digito(char_in) && (cnt_q < CNT_MAX)) begin
                        // For '0'..'9' the low nibble already equals char_in - '0'.
                        bcd_d = {bcd_q[11:0], char_in[3:0]};
                        cnt_d = cnt_q + CNT_UNO;
                    end else begin
                        poison_d = 1'b1;
                    end
                end
            end
            CONVIERTE: begin
                shreg_d = ajustado;
                iter_d  = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    estado_d = RESULTADO;
                end
            end
            RESULTADO: begin
                if (rechazo_q || (shreg_q[15:0] > LIMITE)) begin
                    error_d = 1'b1;
                end else begin
                    numero_d = shreg_q[12:0];
                    nvalid_d = 1'b1;
                end
                bcd_d     = '0;
                cnt_d     = '0;
                poison_d  = 1'b0;
                rechazo_d = 1'b0;
                estado_d  = CAPTURA;
            end
            default: begin
                estado_d = CAPTURA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= CAPTURA;
            bcd_q     <= '0;
            cnt_q     <= '0;
            poison_q  <= 1'b0;
            rechazo_q <= 1'b0;
            shreg_q   <= '0;
            iter_q    <= '0;
            numero_q  <= '0;
            nvalid_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            poison_q  <= poison_d;
            rechazo_q <= rechazo_d;
            shreg_q   <= shreg_d;
            iter_q    <= iter_d;
            numero_q  <= numero_d;
            nvalid_q  <= nvalid_d;
            error_q   <= error_d;
        end
    end

    assign ready        = (estado_q == CAPTURA);
    assign numero       = numero_q;
    assign numero_valid = nvalid_q;
    assign error        = error_q;

endmodule
